multicast_crossbar: RTL and testbench

- Parametrised successor to the tagged unicast crossbar: NUM_INPUTS x NUM_OUTPUTS switch whose tag is a destination bitmask, so one beat may go to several outputs at once (multicast).
- Packet-atomic per-output locking, a single global round-robin priority, and all-or-nothing multicast delivery, which together make it deadlock-free.
- Sits between stream producers (operators, DMA readers) and consumers wherever fan-out or fan-in routing of AXI-stream-like beats is needed.

---
 rtl/multicast_crossbar_pkg.sv | 42 ++++
 rtl/multicast_crossbar_xbar_out_slot.sv | 93 +++++++++
 rtl/multicast_crossbar.sv | 149 ++++++++++++++
 tb/tb_multicast_crossbar.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicast_crossbar_pkg.sv
// Shared helpers for multicast_crossbar: round-robin scan, popcount and index-width helper.
package multicast_crossbar_pkg;

   // Helper vectors are sized to this bound and zero-padded, so NUM_INPUTS must not exceed it.
   localparam int MAX_PORTS = 64;
   localparam int IDX_WIDTH = $clog2(MAX_PORTS);

   typedef struct packed {
      logic                 found;
      logic [IDX_WIDTH-1:0] idx;
   } pick_t;

   function automatic int src_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // First set bit of req[0..n-1], scanning upward from ptr and wrapping at n.
   function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                     input int unsigned          n,
                                     input int unsigned          ptr);
      pick_t       res;
      int unsigned cand;
      res = '0;
      for (int unsigned off = 0; off < MAX_PORTS; off++) begin
         cand = ptr + off;
         if (cand >= n) cand = cand - n;
         if (off < n && !res.found && req[cand[IDX_WIDTH-1:0]]) begin
            res.found = 1'b1;
            res.idx   = cand[IDX_WIDTH-1:0];
         end
      end
      return res;
   endfunction

   function automatic logic [IDX_WIDTH:0] popcount(input logic [MAX_PORTS-1:0] v);
      logic [IDX_WIDTH:0] cnt;
      cnt = '0;
      for (int i = 0; i < MAX_PORTS; i++) cnt = cnt + {{IDX_WIDTH{1'b0}}, v[i]};
      return cnt;
   endfunction

endpackage

// File: rtl/multicast_crossbar_xbar_out_slot.sv
// One crossbar output: registered beat, load/drain handshake and the packet lock owner.
module xbar_out_slot
   import multicast_crossbar_pkg::*;
#(
   parameter int DATA_WIDTH    = 512,
   parameter int KEEP_WIDTH    = 64,
   parameter int SRC_WIDTH     = 2,
   parameter int LAST_HANDLING = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [KEEP_WIDTH-1:0] keep_i,
   input  logic                  last_i,
   input  logic [SRC_WIDTH-1:0]  src_i,
   input  logic                  out_ready_i,
   output logic                  free_o,
   output logic                  lock_v_o,
   output logic [SRC_WIDTH-1:0]  lock_id_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [KEEP_WIDTH-1:0] keep_o,
   output logic                  last_o,
   output logic [SRC_WIDTH-1:0]  src_o,
   output logic                  valid_o
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [KEEP_WIDTH-1:0] keep_q, keep_d;
   logic                  last_q, last_d;
   logic [SRC_WIDTH-1:0]  src_q, src_d;
   logic                  lock_v_q, lock_v_d;
   logic [SRC_WIDTH-1:0]  lock_id_q, lock_id_d;

   assign free_o = !valid_q || out_ready_i;

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
      valid_d   = valid_q;
      data_d    = data_q;
      keep_d    = keep_q;
      last_d    = last_q;
      src_d     = src_q;
      lock_v_d  = lock_v_q;
      lock_id_d = lock_id_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         keep_d  = keep_i;
         last_d  = last_i;
         src_d   = src_i;
         // A non-final beat holds this output for its packet; the final beat releases it.
         if (LAST_HANDLING != 0) begin
            lock_v_d  = !last_i;
            lock_id_d = src_i;
         end
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   // NOTE: the datapath registers are reset as well, so outputs read zero rather than X after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         keep_q    <= '0;
         last_q    <= 1'b0;
         src_q     <= '0;
         lock_v_q  <= 1'b0;
         lock_id_q <= '0;
      end else begin
         valid_q   <= valid_d;
         data_q    <= data_d;
         keep_q    <= keep_d;
         last_q    <= last_d;
         src_q     <= src_d;
         lock_v_q  <= lock_v_d;
         lock_id_q <= lock_id_d;
      end
   end

   assign lock_v_o  = lock_v_q;
   assign lock_id_o = lock_id_q;
   assign data_o    = data_q;
   assign keep_o    = keep_q;
   assign last_o    = last_q;
   assign src_o     = src_q;
   assign valid_o   = valid_q;

endmodule

// File: rtl/multicast_crossbar.sv
// NUM_INPUTS x NUM_OUTPUTS multicast stream crossbar with packet locking and global round-robin.
// Define XBAR_DROP_CNT_EN to add the saturating drop_cnt output.
module multicast_crossbar
   import multicast_crossbar_pkg::*;
#(
   parameter int  NUM_INPUTS    = 4,
   parameter int  NUM_OUTPUTS   = 4,
   parameter int  DATA_WIDTH    = 512,
   parameter int  KEEP_WIDTH    = DATA_WIDTH / 8,
   parameter int  LAST_HANDLING = 1,
   parameter int  FILTER_KEEP   = 1,
   localparam int SRC_WIDTH     = src_width(NUM_INPUTS)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data,
   input  logic [NUM_INPUTS*KEEP_WIDTH-1:0]  in_keep,
   input  logic [NUM_INPUTS-1:0]             in_last,
   input  logic [NUM_INPUTS*NUM_OUTPUTS-1:0] in_dest,
   input  logic [NUM_INPUTS-1:0]             in_valid,
   output logic [NUM_INPUTS-1:0]             in_ready,
   output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
   output logic [NUM_OUTPUTS*KEEP_WIDTH-1:0] out_keep,
   output logic [NUM_OUTPUTS-1:0]            out_last,
   output logic [NUM_OUTPUTS*SRC_WIDTH-1:0]  out_src,
   output logic [NUM_OUTPUTS-1:0]            out_valid,
`ifdef XBAR_DROP_CNT_EN
   output logic [31:0]                       drop_cnt,
`endif
   input  logic [NUM_OUTPUTS-1:0]            out_ready
);

   logic [DATA_WIDTH-1:0]  in_data_a [NUM_INPUTS];
   logic [KEEP_WIDTH-1:0]  in_keep_a [NUM_INPUTS];
   logic [NUM_OUTPUTS-1:0] in_dest_a [NUM_INPUTS];
   logic [NUM_INPUTS-1:0]  keep_drop, drop, fire;

   logic [NUM_OUTPUTS-1:0] slot_free, slot_lock_v, load, pick_ok;
   logic [SRC_WIDTH-1:0]   slot_lock_id [NUM_OUTPUTS];
   logic [MAX_PORTS-1:0]   req [NUM_OUTPUTS];
   pick_t                  pick [NUM_OUTPUTS];
   logic [SRC_WIDTH-1:0]   pick_idx [NUM_OUTPUTS];

   logic [MAX_PORTS-1:0]   adv;
   pick_t                  adv_pick;
   int                     nxt;
   logic [SRC_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

   always_comb begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
         in_data_a[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
         in_keep_a[i] = in_keep[i*KEEP_WIDTH +: KEEP_WIDTH];
         in_dest_a[i] = in_dest[i*NUM_OUTPUTS +: NUM_OUTPUTS];
         keep_drop[i] = (FILTER_KEEP != 0) && (in_keep_a[i] == '0) && !in_last[i];
         drop[i]      = in_valid[i] && ((in_dest_a[i] == '0) || keep_drop[i]);
      end
   end

   // Beats about to be filtered never compete for an output, so they cannot stall real traffic.
   always_comb begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
         req[o] = '0;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            req[o][i] = in_valid[i] && !keep_drop[i] && in_dest_a[i][o]
                        && (!slot_lock_v[o] || slot_lock_id[o] == SRC_WIDTH'(i));
         end
         pick[o]     = rr_pick(req[o], NUM_INPUTS, 32'(rr_ptr_q));
         pick_ok[o]  = pick[o].found && slot_free[o];
         pick_idx[o] = SRC_WIDTH'(pick[o].idx);
      end
   end

   // All-or-nothing: an input fires only if it won every output in its destination mask.
   always_comb begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
         fire[i] = in_valid[i] && !drop[i];
         for (int o = 0; o < NUM_OUTPUTS; o++) begin
            if (in_dest_a[i][o] && !(pick_ok[o] && pick_idx[o] == SRC_WIDTH'(i))) fire[i] = 1'b0;
         end
      end
   end

   assign in_ready = fire | drop;

   always_comb begin
      for (int o = 0; o < NUM_OUTPUTS; o++) load[o] = pick_ok[o] && fire[pick_idx[o]];
   end

   for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_slot
      xbar_out_slot #(
         .DATA_WIDTH    (DATA_WIDTH),
         .KEEP_WIDTH    (KEEP_WIDTH),
         .SRC_WIDTH     (SRC_WIDTH),
         .LAST_HANDLING (LAST_HANDLING)
      ) u_slot (
         .clk         (clk),
         .rst_n       (rst_n),
         .load_i      (load[o]),
         .data_i      (in_data_a[pick_idx[o]]),
         .keep_i      (in_keep_a[pick_idx[o]]),
         .last_i      (in_last[pick_idx[o]]),
         .src_i       (pick_idx[o]),
         .out_ready_i (out_ready[o]),
         .free_o      (slot_free[o]),
         .lock_v_o    (slot_lock_v[o]),
         .lock_id_o   (slot_lock_id[o]),
         .data_o      (out_data[o*DATA_WIDTH +: DATA_WIDTH]),
         .keep_o      (out_keep[o*KEEP_WIDTH +: KEEP_WIDTH]),
         .last_o      (out_last[o]),
         .src_o       (out_src[o*SRC_WIDTH +: SRC_WIDTH]),
         .valid_o     (out_valid[o])
      );
   end

   // The pointer advances past the packet-ending winner nearest the current priority position.
   always_comb begin
      adv = '0;
      for (int i = 0; i < NUM_INPUTS; i++) adv[i] = fire[i] && (LAST_HANDLING == 0 || in_last[i]);
      adv_pick = rr_pick(adv, NUM_INPUTS, 32'(rr_ptr_q));
      nxt      = int'(adv_pick.idx) + 1;
      rr_ptr_d = rr_ptr_q;
      if (adv_pick.found) rr_ptr_d = (nxt >= NUM_INPUTS) ? '0 : SRC_WIDTH'(nxt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
   end

`ifdef XBAR_DROP_CNT_EN
   logic [MAX_PORTS-1:0] drop_wide;
   logic [32:0]          drop_sum;
   logic [31:0]          drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_wide  = MAX_PORTS'(drop);
      drop_sum   = {1'b0, drop_cnt_q} + 33'(popcount(drop_wide));
      drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_multicast_crossbar.sv
// Directed bench for multicast_crossbar: a vector table plus lock, fairness and async-reset sequences.
module tb_multicast_crossbar;

   localparam int NI = 4;
   localparam int NO = 4;
   localparam int DW = 16;
   localparam int KW = 2;
   localparam int SW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NI*DW-1:0]  in_data;
   logic [NI*KW-1:0]  in_keep;
   logic [NI-1:0]     in_last;
   logic [NI*NO-1:0]  in_dest;
   logic [NI-1:0]     in_valid;
   logic [NI-1:0]     in_ready;
   logic [NO*DW-1:0]  out_data;
   logic [NO*KW-1:0]  out_keep;
   logic [NO-1:0]     out_last;
   logic [NO*SW-1:0]  out_src;
   logic [NO-1:0]     out_valid;
   logic [NO-1:0]     out_ready;
`ifdef XBAR_DROP_CNT_EN
   logic [31:0]       drop_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicast_crossbar #(
      .NUM_INPUTS    (NI),
      .NUM_OUTPUTS   (NO),
      .DATA_WIDTH    (DW),
      .KEEP_WIDTH    (KW),
      .LAST_HANDLING (1),
      .FILTER_KEEP   (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_keep   (in_keep),
      .in_last   (in_last),
      .in_dest   (in_dest),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_last  (out_last),
      .out_src   (out_src),
      .out_valid (out_valid),
`ifdef XBAR_DROP_CNT_EN
      .drop_cnt  (drop_cnt),
`endif
      .out_ready (out_ready)
   );

   typedef struct {
      string       name;
      logic [3:0]  valid;
      logic [15:0] dest;
      logic [63:0] data;
      logic [7:0]  keep;
      logic [3:0]  last;
      logic [3:0]  oready;
      logic [3:0]  exp_ready;
      logic [3:0]  exp_ovalid;
      logic [7:0]  exp_src;
      logic [63:0] exp_data;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [15:0] d, input logic [63:0] dat,
                        input logic [7:0] k, input logic [3:0] l, input logic [3:0] r);
      in_valid  = v;
      in_dest   = d;
      in_data   = dat;
      in_keep   = k;
      in_last   = l;
      out_ready = r;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(4'h0, 16'h0, 64'h0, 8'hFF, 4'hF, 4'hF);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic vec_t mk(string n, logic [3:0] v, logic [15:0] d, logic [63:0] dat,
                               logic [7:0] k, logic [3:0] l, logic [3:0] r, logic [3:0] er,
                               logic [3:0] ev, logic [7:0] es, logic [63:0] ed);
      vec_t t;
      t.name = n; t.valid = v; t.dest = d; t.data = dat; t.keep = k; t.last = l; t.oready = r;
      t.exp_ready = er; t.exp_ovalid = ev; t.exp_src = es; t.exp_data = ed;
      return t;
   endfunction

   initial begin
      // Each row is one cycle; state (outputs, rr_ptr) carries from row to row.
      vecs[0]  = mk("unicast",     4'b0001, 16'h0002, 64'h0000_0000_0000_00A5, 8'hFF, 4'hF, 4'hF,
                    4'b0001, 4'b0010, 8'h00, 64'h0000_0000_00A5_0000);
      vecs[1]  = mk("idle",        4'b0000, 16'h0000, 64'h0,                   8'hFF, 4'hF, 4'hF,
                    4'b0000, 4'b0000, 8'h00, 64'h0);
      vecs[2]  = mk("fill_out2",   4'b0010, 16'h0040, 64'h0000_0000_1111_0000, 8'hFF, 4'hF, 4'hF,
                    4'b0010, 4'b0100, 8'h10, 64'h0000_1111_0000_0000);
      vecs[3]  = mk("mc_blocked",  4'b0100, 16'h0500, 64'h0000_2222_0000_0000, 8'hFF, 4'hF, 4'hB,
                    4'b0000, 4'b0100, 8'h10, 64'h0000_1111_0000_0000);
      vecs[4]  = mk("mc_release",  4'b0100, 16'h0500, 64'h0000_2222_0000_0000, 8'hFF, 4'hF, 4'hF,
                    4'b0100, 4'b0101, 8'h22, 64'h0000_2222_0000_2222);
      vecs[5]  = mk("drop_dest0",  4'b0001, 16'h0000, 64'h0000_0000_0000_DEAD, 8'hFF, 4'hF, 4'hF,
                    4'b0001, 4'b0000, 8'h00, 64'h0);
      vecs[6]  = mk("drop_keep0",  4'b0010, 16'h0010, 64'h0000_0000_BEEF_0000, 8'hF3, 4'hD, 4'hF,
                    4'b0010, 4'b0000, 8'h00, 64'h0);
      vecs[7]  = mk("disjoint",    4'b1001, 16'h8001, 64'h3B3B_0000_0000_0A0A, 8'hFF, 4'hF, 4'hF,
                    4'b1001, 4'b1001, 8'hC0, 64'h3B3B_0000_0000_0A0A);
      vecs[8]  = mk("contend_a",   4'b0110, 16'h0220, 64'h0000_0B02_0B01_0000, 8'hFF, 4'hF, 4'hF,
                    4'b0010, 4'b0010, 8'h04, 64'h0000_0000_0B01_0000);
      vecs[9]  = mk("contend_b",   4'b0110, 16'h0220, 64'h0000_0B02_0B01_0000, 8'hFF, 4'hF, 4'hF,
                    4'b0100, 4'b0010, 8'h08, 64'h0000_0000_0B02_0000);
      vecs[10] = mk("mc_vs_uni",   4'b0011, 16'h0023, 64'h0000_0000_0C01_0C00, 8'hFF, 4'hF, 4'hF,
                    4'b0001, 4'b0011, 8'h00, 64'h0000_0000_0C00_0C00);

      drive(4'h0, 16'h0, 64'h0, 8'hFF, 4'hF, 4'hF);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("reset out_valid", 64'(out_valid), 64'h0);
      check("reset out_data",  64'(out_data),  64'h0);
      check("reset out_src",   64'(out_src),   64'h0);
      check("reset in_ready",  64'(in_ready),  64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 11; n++) begin
         @(negedge clk);
         drive(vecs[n].valid, vecs[n].dest, vecs[n].data, vecs[n].keep, vecs[n].last, vecs[n].oready);
         #1;
         check({vecs[n].name, " in_ready"}, 64'(in_ready), 64'(vecs[n].exp_ready));
         @(posedge clk);
         #1;
         check({vecs[n].name, " out_valid"}, 64'(out_valid), 64'(vecs[n].exp_ovalid));
         for (int o = 0; o < NO; o++) begin
            if (vecs[n].exp_ovalid[o]) begin
               check({vecs[n].name, " out_data"}, 64'(out_data[o*DW +: DW]),
                     64'(vecs[n].exp_data[o*DW +: DW]));
               check({vecs[n].name, " out_src"}, 64'(out_src[o*SW +: SW]),
                     64'(vecs[n].exp_src[o*SW +: SW]));
            end
         end
      end
`ifdef XBAR_DROP_CNT_EN
      check("drop_cnt", 64'(drop_cnt), 64'd2);
`endif

      // Packet lock: in0's 3-beat packet holds out0 against in1; pointer then favours in1.
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(4'b0011, 16'h0011, {32'h0, 16'h1000, 16'(16'h0100 + c)}, 8'hFF,
               {2'b00, 1'b1, (c >= 2)}, 4'hF);
         #1;
         check("lock in_ready", 64'(in_ready), (c == 3) ? 64'h2 : 64'h1);
         @(posedge clk);
         #1;
         check("lock out_valid", 64'(out_valid), 64'h1);
         check("lock out_src",  64'(out_src[1:0]),   (c == 3) ? 64'd1 : 64'd0);
         check("lock out_data", 64'(out_data[15:0]), (c == 3) ? 64'h1000 : 64'(16'h0100 + c));
         check("lock out_last", 64'(out_last[0]),    (c >= 2) ? 64'd1 : 64'd0);
      end

      // Fairness: four single-beat streams into out3 rotate with no bubbles.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         drive(4'hF, 16'h8888, 64'h00F3_00F2_00F1_00F0, 8'hFF, 4'hF, 4'hF);
         #1;
         check("fair in_ready", 64'(in_ready), 64'(1 << (c % 4)));
         @(posedge clk);
         #1;
         check("fair out_valid", 64'(out_valid), 64'h8);
         check("fair out_src",  64'(out_src[7:6]),    64'(c % 4));
         check("fair out_data", 64'(out_data[63:48]), 64'(16'h00F0 + (c % 4)));
      end

      // Async reset mid-packet clears valid and lock without a clock edge.
      do_reset();
      @(negedge clk);
      drive(4'b0001, 16'h0001, 64'h0000_0000_0000_0AAA, 8'hFF, 4'b0000, 4'hF);
      @(posedge clk);
      #1;
      check("arst locked out_valid", 64'(out_valid), 64'h1);
      drive(4'h0, 16'h0, 64'h0, 8'hFF, 4'hF, 4'hF);
      #1 rst_n = 1'b0;
      #1;
      check("arst out_valid", 64'(out_valid), 64'h0);
      check("arst out_data",  64'(out_data),  64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0010, 16'h0010, 64'h0000_0000_0BBB_0000, 8'hFF, 4'b0010, 4'hF);
      #1;
      check("arst new in_ready", 64'(in_ready), 64'h2);
      @(posedge clk);
      #1;
      check("arst new out_valid", 64'(out_valid),     64'h1);
      check("arst new out_src",   64'(out_src[1:0]),   64'd1);
      check("arst new out_data",  64'(out_data[15:0]), 64'h0BBB);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
